// File: rtl/control_bus_rtc.sv
// control_bus_rtc: bus-cycle engine for the RTC multiplexed AD bus (address phase, data phase, completion handshake).
module control_bus_rtc #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_activa,
  input  logic       i_w,
  input  logic [7:0] i_dir,
  input  logic [7:0] i_dato_in,
  input  logic [7:0] i_ad_in,
  output logic       o_fin,
  output logic [7:0] o_dato_out,
  output logic       o_ocupado,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_a_d,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe
);
  localparam int TMAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                            : ((T_PULSE > T_HOLD) ? T_PULSE : T_HOLD);
  localparam int CW = $clog2(TMAX + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_AS, S_AP, S_AH, S_DS, S_DP, S_DH, S_DONE, S_WR
  } state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic       r_w;
  logic [7:0] r_dir, r_dat;
  logic       w_exp, w_w, w_addr, w_data;
  logic [7:0] w_dir, w_dat;
  assign w_exp = (r_cnt == '0);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_activa ? S_AS : S_IDLE;
      S_AS:    w_next = w_exp ? S_AP : S_AS;
      S_AP:    w_next = w_exp ? S_AH : S_AP;
      S_AH:    w_next = w_exp ? S_DS : S_AH;
      S_DS:    w_next = w_exp ? S_DP : S_DS;
      S_DP:    w_next = w_exp ? S_DH : S_DP;
      S_DH:    w_next = w_exp ? S_DONE : S_DH;
      S_DONE:  w_next = S_WR;
      S_WR:    w_next = i_activa ? S_WR : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  // Outputs are registered from the next state, so on acceptance the fresh request fields are used directly.
  assign w_w    = (r_state == S_IDLE) ? i_w : r_w;
  assign w_dir  = (r_state == S_IDLE) ? i_dir : r_dir;
  assign w_dat  = (r_state == S_IDLE) ? i_dato_in : r_dat;
  assign w_addr = (w_next == S_AS) || (w_next == S_AP) || (w_next == S_AH);
  assign w_data = (w_next == S_DS) || (w_next == S_DP) || (w_next == S_DH);
  assign w_load = ((w_next == S_AS) || (w_next == S_DS)) ? CW'(T_SETUP - 1) :
                  ((w_next == S_AP) || (w_next == S_DP)) ? CW'(T_PULSE - 1) : CW'(T_HOLD - 1);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_w        <= 1'b0;
      r_dir      <= '0;
      r_dat      <= '0;
      o_fin      <= 1'b0;
      o_dato_out <= '0;
      o_ocupado  <= 1'b0;
      o_cs_n     <= 1'b1;
      o_rd_n     <= 1'b1;
      o_wr_n     <= 1'b1;
      o_a_d      <= 1'b1;
      o_ad_out   <= '0;
      o_ad_oe    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? w_load : (w_exp ? r_cnt : r_cnt - 1'b1);
      if (r_state == S_IDLE && i_activa) begin
        r_w   <= i_w;
        r_dir <= i_dir;
        r_dat <= i_dato_in;
      end
      if (r_state == S_DP && w_exp && !r_w) o_dato_out <= i_ad_in;
      o_fin     <= (w_next == S_DONE);
      o_ocupado <= (w_next != S_IDLE);
      o_cs_n    <= !(w_addr || w_data);
      o_a_d     <= !w_addr;
      o_ad_oe   <= w_addr || (w_data && w_w);
      o_ad_out  <= w_addr ? w_dir : ((w_data && w_w) ? w_dat : 8'h00);
      o_wr_n    <= !((w_next == S_AP) || (w_next == S_DP && w_w));
      o_rd_n    <= !(w_next == S_DP && !w_w);
    end
  end
endmodule
